// File: rtl/cmd_uart_responder.sv
// cmd_uart_responder: UART link endpoint for the remote command channel.
// Assembles two received bytes into a 16-bit command and serializes responses.
module cmd_uart_responder #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        ASM_HIGH,
        ASM_LOW
    } asm_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    // ---------------- receiver ----------------
    rx_state_t       rx_state, rx_next;
    logic            rx_s1, rx_s2, rx_d;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bits;
    logic [7:0]      rx_sh;
    logic            rx_tick, rx_fall;
    logic            rx_ld_half, rx_ld_full, rx_shift;
    logic            stop_ok, stop_bad;
    logic            rx_vld, rx_err;

    assign rx_fall = rx_d & ~rx_s2;
    assign rx_tick = (rx_cnt == '0);

    // Bring RX into the clock domain; rx_d keeps the previous level for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // Receiver next state; a start bit that is high again at mid-bit is a glitch
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Receiver control strobes
    always_comb begin
        rx_ld_half = 1'b0;
        rx_ld_full = 1'b0;
        rx_shift   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        unique case (rx_state)
            RX_IDLE:  rx_ld_half = rx_fall;
            RX_START: rx_ld_full = rx_tick & ~rx_s2;
            RX_DATA: begin
                rx_shift   = rx_tick;
                rx_ld_full = rx_tick;
            end
            RX_STOP: begin
                stop_ok  = rx_tick & rx_s2;
                stop_bad = rx_tick & ~rx_s2;
            end
            default: ;
        endcase
    end

    // Receiver bit timer, data shifter and byte/framing-error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt  <= '0;
            rx_bits <= '0;
            rx_sh   <= '0;
            rx_vld  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            rx_vld <= stop_ok;
            rx_err <= stop_bad;
            if (rx_ld_half) begin
                rx_cnt  <= HALF;
                rx_bits <= '0;
            end else if (rx_ld_full) begin
                rx_cnt <= FULL;
            end else if (!rx_tick) begin
                rx_cnt <= rx_cnt - 1'b1;
            end
            if (rx_shift) begin
                rx_sh   <= {rx_s2, rx_sh[7:1]};
                rx_bits <= rx_bits + 3'd1;
            end
        end
    end

    // ---------------- command assembly ----------------
    asm_state_t asm_state, asm_next;
    logic [7:0] high_byte;
    logic       ld_high, ld_cmd;

    // Assembly state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) asm_state <= ASM_HIGH;
        else     asm_state <= asm_next;
    end

    // Assembly next state; a framing error always resynchronizes to the high byte
    always_comb begin
        asm_next = asm_state;
        unique case (asm_state)
            ASM_HIGH: if (rx_vld) asm_next = ASM_LOW;
            ASM_LOW:  if (rx_vld || rx_err) asm_next = ASM_HIGH;
            default:  asm_next = ASM_HIGH;
        endcase
    end

    // Assembly load strobes
    always_comb begin
        ld_high = 1'b0;
        ld_cmd  = 1'b0;
        unique case (asm_state)
            ASM_HIGH: ld_high = rx_vld;
            ASM_LOW:  ld_cmd  = rx_vld;
            default: ;
        endcase
    end

    // Command and ready flag; a completing command beats a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_byte <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            if (ld_high) high_byte <= rx_sh;
            if (ld_cmd)  cmd <= {high_byte, rx_sh};
            if (ld_cmd)
                cmd_rdy <= 1'b1;
            else if (ld_high || clr_cmd_rdy)
                cmd_rdy <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic [9:0]    tx_sh;
    logic          tx_tick, tx_last;
    logic          tx_load, tx_shift, tx_end, tx_dec;

    assign tx_tick = (tx_cnt == '0);
    assign tx_last = tx_tick && (tx_bits == 4'd9);
    assign TX      = tx_sh[0];

    // Transmitter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    // Transmitter next state; trmt is only honoured while idle
    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE: if (trmt) tx_next = TX_BUSY;
            TX_BUSY: if (tx_last) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // Transmitter control strobes
    always_comb begin
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        tx_end   = 1'b0;
        tx_dec   = 1'b0;
        unique case (tx_state)
            TX_IDLE: tx_load = trmt;
            TX_BUSY: begin
                tx_shift = tx_tick;
                tx_end   = tx_last;
                tx_dec   = ~tx_tick;
            end
            default: ;
        endcase
    end

    // Frame shifter fills with ones so TX idles high, including during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_bits <= '0;
            tx_done <= 1'b0;
        end else if (tx_load) begin
            tx_sh   <= {1'b1, resp, 1'b0};
            tx_cnt  <= FULL;
            tx_bits <= '0;
            tx_done <= 1'b0;
        end else if (tx_shift) begin
            tx_sh   <= {1'b1, tx_sh[9:1]};
            tx_cnt  <= FULL;
            tx_bits <= tx_bits + 4'd1;
            if (tx_end) tx_done <= 1'b1;
        end else if (tx_dec) begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_uart_responder.sv
// tb_cmd_uart_responder: directed bench for the command UART responder.
// Runs with a short bit period so full frames stay cheap.
module tb_cmd_uart_responder;

    localparam int B = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    logic [9:0] fr;

    cmd_uart_responder #(.BAUD_DIV(B)) dut (
        .clk(clk),
        .rst(rst),
        .RX(RX),
        .TX(TX),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp),
        .trmt(trmt),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame starting at the current falling clock edge
    task automatic send_byte(input logic [7:0] d, input logic stop);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (B) @(negedge clk);
        end
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        trmt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", TX, 1);
        chk("rst_cmd", cmd, 0);
        chk("rst_rdy", cmd_rdy, 0);
        chk("rst_done", tx_done, 0);

        // basic command and clear
        send_byte(8'h47, 1'b1);
        chk("hi_rdy", cmd_rdy, 0);
        send_byte(8'hF3, 1'b1);
        chk("cmd_47f3", cmd, 16'h47F3);
        chk("rdy_47f3", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("clr_rdy", cmd_rdy, 0);
        chk("clr_cmd", cmd, 16'h47F3);

        // response 0xA5, second trmt during bit 3 is ignored
        fr = {1'b1, 8'hA5, 1'b0};
        resp = 8'hA5;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        chk("tx_done_clr", tx_done, 0);
        for (int k = 0; k < 10; k++) begin
            chk("tx_first", TX, fr[k]);
            if (k == 3) begin
                resp = 8'h00;
                trmt = 1'b1;
                @(negedge clk);
                trmt = 1'b0;
                resp = 8'hA5;
                repeat (B - 2) @(negedge clk);
            end else begin
                repeat (B - 1) @(negedge clk);
            end
            chk("tx_last", TX, fr[k]);
            chk("tx_busy_done", tx_done, 0);
            @(negedge clk);
        end
        chk("tx_done_set", tx_done, 1);
        chk("tx_idle", TX, 1);

        // framing error drops the first byte
        send_byte(8'h12, 1'b0);
        repeat (B) @(negedge clk);
        chk("ferr_cmd", cmd, 16'h47F3);
        chk("ferr_rdy", cmd_rdy, 0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        chk("cmd_3456", cmd, 16'h3456);
        chk("rdy_3456", cmd_rdy, 1);

        // short low glitch is rejected
        RX = 1'b0;
        repeat (B / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch_cmd", cmd, 16'h3456);
        chk("glitch_rdy", cmd_rdy, 1);
        send_byte(8'hA0, 1'b1);
        chk("a0_rdy", cmd_rdy, 0);
        send_byte(8'h05, 1'b1);
        chk("cmd_a005", cmd, 16'hA005);
        chk("rdy_a005", cmd_rdy, 1);

        // reset mid low byte and mid transmit
        send_byte(8'h77, 1'b1);
        resp = 8'hA5;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        RX = 1'b0;
        repeat (2 * B + B / 2) @(negedge clk);
        chk("pre_rst_tx", TX, 0);
        rst = 1'b1;
        #1;
        chk("arst_tx", TX, 1);
        chk("arst_cmd", cmd, 0);
        chk("arst_rdy", cmd_rdy, 0);
        chk("arst_done", tx_done, 0);
        RX = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", TX, 1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        chk("cmd_5ac3", cmd, 16'h5AC3);
        chk("rdy_5ac3", cmd_rdy, 1);
        resp = 8'h3C;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        chk("tx2_start", TX, 0);
        repeat (10 * B - 1) @(negedge clk);
        chk("tx2_busy", tx_done, 0);
        @(negedge clk);
        chk("tx2_done", tx_done, 1);

        // new high byte clears ready; clear coincident with set loses
        send_byte(8'h2B, 1'b1);
        chk("2b_rdy", cmd_rdy, 0);
        chk("2b_cmd", cmd, 16'h5AC3);
        fork
            send_byte(8'h1C, 1'b1);
            begin
                repeat (3 + B / 2 + 9 * B) @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
            end
        join
        chk("cmd_2b1c", cmd, 16'h2B1C);
        chk("set_wins", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("final_clr", cmd_rdy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_uart_responder.md
# cmd_uart_responder

Robot-side end of the remote command link. Receives the two-byte commands sent by the remote UART commander and assembles them into a 16-bit command for the command processor. Serializes the processor's 8-bit response byte (e.g. 0xA5 positive acknowledge) back to the remote. Sits between the RX/TX pins and the command processor inside the top-level knight controller.

## Interface
- BAUD_DIV, 2604, clocks per UART bit (19200 baud at 50 MHz); must be ≥ 16.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  serial in from remote; asynchronous, idle high.
- TX  output  1  serial out to remote; idle high.
- cmd  output  16  assembled command; high byte first on the wire.
- cmd_rdy  output  1  level; a new command is valid on cmd.
- clr_cmd_rdy  input  1  single-cycle pulse from the processor; clears cmd_rdy.
- resp  input  8  response byte, sampled on trmt.
- trmt  input  1  single-cycle pulse; start transmitting resp.
- tx_done  output  1  level; last response fully sent.

## Operation
- Frame format: 8N1, LSB first, 1 start bit (0), 8 data bits, 1 stop bit (1).
- RX front end:
  - Double-flop synchronizer, reset to 1.
  - Receiver states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge; bit counter loads BAUD_DIV/2.
  - At mid-start, RX must still be 0, else return to IDLE (glitch rejection).
  - DATA samples 8 bits, one every BAUD_DIV clocks, into a right-shifting register.
  - STOP samples the stop bit: 1 → byte valid (one-cycle internal pulse); 0 → framing error, byte discarded.
- Assembly FSM:
  - States: HIGH (await high byte), LOW (await low byte).
  - HIGH + byte: store high byte, clear cmd_rdy, →LOW.
  - LOW + byte: cmd ← {high, low}, set cmd_rdy, →HIGH.
  - Framing error in either state: →HIGH; any partial high byte is dropped; cmd and cmd_rdy unchanged.
  - cmd holds its value until the next complete command.
- cmd_rdy:
  - Cleared by clr_cmd_rdy or by a new high byte.
  - If clr_cmd_rdy and the setting event coincide, set wins.
- Transmitter:
  - States: IDLE, BUSY.
  - trmt in IDLE loads {1, resp, 0} into a 10-bit shifter, clears tx_done, →BUSY.
  - TX = shifter LSB; the shifter shifts every BAUD_DIV clocks.
  - After 10 bit periods: →IDLE, set tx_done.
  - trmt while BUSY is ignored; the current frame is not corrupted.
- TX and RX are fully independent; simultaneous receive and transmit are legal.

## Timing
- Reset values:
  - TX=1, cmd=0, cmd_rdy=0, tx_done=0.
  - Both serial FSMs in IDLE, assembly FSM in HIGH.
- rst asserted mid-frame aborts both directions immediately; TX goes to 1 asynchronously.
- RX latency: cmd_rdy rises 1 clk after the low byte's stop-bit sample, i.e. about 2 clk sync + 9.5 bit periods after that byte's start edge.
- TX latency:
  - TX goes low on the clk edge after trmt.
  - Each bit lasts exactly BAUD_DIV clocks.
  - tx_done rises exactly 10×BAUD_DIV clocks after TX first went low.
- Bit counters are sized to hold BAUD_DIV and reload on each bit; no drift accumulates over a frame.

## Test plan
- Send bytes 0x47 then 0xF3 → cmd=16'h47F3, cmd_rdy=1; clr_cmd_rdy pulse → cmd_rdy=0 next clk, cmd still 16'h47F3.
- trmt with resp=0xA5 → TX sequence 0,1,0,1,0,0,1,0,1,1, each bit BAUD_DIV clocks; tx_done=1 at 10×BAUD_DIV; a second trmt mid-frame changes nothing.
- Send 0x12 with its stop bit forced to 0, then 0x34, 0x56 → framing error drops 0x12; cmd=16'h3456, cmd_rdy=1.
- RX low pulse of BAUD_DIV/4 clocks → no byte accepted, FSM back in IDLE; the next proper command 0xA0,0x05 → cmd=16'hA005.
- Assert rst during the low byte of a command and during TX of 0xA5 → all outputs at reset values, TX=1; a following full command and transmit behave normally.
- With cmd_rdy=1, send command 0x2B,0x1C with no clr → cmd_rdy drops when 0x2B is received and re-rises with cmd=16'h2B1C; clr_cmd_rdy coincident with the set → cmd_rdy stays 1.
